// File: rtl/lfsr_chk_pkg.sv
// lfsr_chk_pkg: state type, byte width and LFSR prediction shared by lfsr_checker
package lfsr_chk_pkg;
  localparam int LFSR_W = 8;
  typedef enum logic [1:0] {SEARCH = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x, input logic [2:0] t1, input logic [2:0] t2);
    return {x[0] ^ x[t1] ^ x[t2], x[LFSR_W-1:1]};
  endfunction
endpackage

// File: rtl/lfsr_chk_if.sv
// lfsr_chk_if: byte stream (data_in, valid, clear) in, lock/error status (locked, err_pulse, err_count) out
interface lfsr_chk_if #(parameter int ERR_CNT_W = 16);
  import lfsr_chk_pkg::*;
  logic [LFSR_W-1:0] data_in;
  logic valid;
  logic clear;
  logic locked;
  logic err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (output data_in, valid, clear, input locked, err_pulse, err_count);
  modport slave (input data_in, valid, clear, output locked, err_pulse, err_count);
endinterface

// File: rtl/lfsr_chk_popcnt.sv
// lfsr_chk_popcnt: combinational population count of one LFSR byte
module lfsr_chk_popcnt
  import lfsr_chk_pkg::*;
(
  input  logic [LFSR_W-1:0] x,
  output logic [3:0]        cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < LFSR_W; i++) cnt = cnt + {3'd0, x[i]};
  end
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: predicts an LFSR byte stream, locks on it and counts locked mismatches (LFSR_CHK_BITCNT_EN: count bit errors)
module lfsr_checker
  import lfsr_chk_pkg::*;
#(
  parameter int TAP_ONE       = 2,
  parameter int TAP_TWO       = 4,
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_ERRORS = 3,
  parameter int ERR_CNT_W     = 16
) (
  input logic       clk,
  input logic       reset_n,
  lfsr_chk_if.slave bus
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_ERRORS + 1);
  localparam int SW = ERR_CNT_W + 4;
  localparam logic [2:0] T1 = 3'(TAP_ONE);
  localparam logic [2:0] T2 = 3'(TAP_TWO);
  state_t state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [UW-1:0] cerr_q, cerr_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic locked_q, locked_d;
  logic pulse_q, pulse_d;
  logic [3:0] inc;
  logic [SW-1:0] sum;
  logic hit;
`ifdef LFSR_CHK_BITCNT_EN
  lfsr_chk_popcnt u_popcnt (.x(bus.data_in ^ exp_q), .cnt(inc));
`else
  assign inc = 4'd1;
`endif
  assign hit = bus.data_in == exp_q;
  assign sum = SW'(cnt_q) + SW'(inc);
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    mcnt_d = mcnt_q;
    cerr_d = cerr_q;
    cnt_d = cnt_q;
    pulse_d = 1'b0;
    if (bus.valid) begin
      case (state_q)
        SEARCH: begin
          if (bus.data_in != '0) begin
            state_d = SYNC;
            exp_d = lfsr_next(bus.data_in, T1, T2);
            mcnt_d = '0;
          end
        end
        SYNC: begin
          if (hit) begin
            mcnt_d = mcnt_q + MW'(1);
            exp_d = lfsr_next(bus.data_in, T1, T2);
            if (mcnt_d == MW'(LOCK_COUNT)) begin
              state_d = LOCKED;
              cerr_d = '0;
            end
          end else if (bus.data_in == '0) begin
            state_d = SEARCH;
          end else begin
            exp_d = lfsr_next(bus.data_in, T1, T2);
            mcnt_d = '0;
          end
        end
        default: begin
          // flywheel: once locked the prediction never reseeds from data_in
          exp_d = lfsr_next(exp_q, T1, T2);
          cerr_d = hit ? '0 : cerr_q + UW'(1);
          pulse_d = !hit;
          cnt_d = hit ? cnt_q : (|sum[SW-1:ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0]);
          state_d = (!hit && cerr_d == UW'(UNLOCK_ERRORS)) ? SEARCH : state_q;
        end
      endcase
    end
    if (bus.clear) cnt_d = '0;
    locked_d = state_d == LOCKED;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      exp_q <= '0;
      mcnt_q <= '0;
      cerr_q <= '0;
      cnt_q <= '0;
      locked_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      mcnt_q <= mcnt_d;
      cerr_q <= cerr_d;
      cnt_q <= cnt_d;
      locked_q <= locked_d;
      pulse_q <= pulse_d;
    end
  end
  assign bus.locked = locked_q;
  assign bus.err_pulse = pulse_q;
  assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: table vectors, corner sequences and randomized model comparison for lfsr_checker
module tb_lfsr_checker;
  localparam int TAP_ONE = 2;
  localparam int TAP_TWO = 4;
  localparam int LOCK = 4;
  localparam int UNLOCK = 3;
`ifdef LFSR_CHK_BITCNT_EN
  localparam bit BITCNT = 1'b1;
  localparam int E10 = 6, E11 = 12, E12 = 18;
`else
  localparam bit BITCNT = 1'b0;
  localparam int E10 = 2, E11 = 3, E12 = 4;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  lfsr_chk_if #(.ERR_CNT_W(16)) a ();
  lfsr_chk_if #(.ERR_CNT_W(2)) b ();
  lfsr_checker #(.TAP_ONE(TAP_ONE), .TAP_TWO(TAP_TWO), .LOCK_COUNT(LOCK), .UNLOCK_ERRORS(UNLOCK), .ERR_CNT_W(16))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(a.slave));
  lfsr_checker #(.TAP_ONE(TAP_ONE), .TAP_TWO(TAP_TWO), .LOCK_COUNT(LOCK), .UNLOCK_ERRORS(8), .ERR_CNT_W(2))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(b.slave));
  int checks = 0;
  int errors = 0;
  int m_mode, m_exp, m_run, m_bad, m_cnt;
  bit m_pulse;
  typedef struct {
    logic [7:0] d;
    bit v;
    bit c;
    bit lk;
    bit ep;
    int ec;
  } vec_t;
  vec_t vt[18];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask
  function automatic int nx(input int x);
    int fb = (x ^ (x >> TAP_ONE) ^ (x >> TAP_TWO)) & 1;
    return (x >> 1) | (fb << 7);
  endfunction
  task automatic model_reset();
    m_mode = 0;
    m_exp = 0;
    m_run = 0;
    m_bad = 0;
    m_cnt = 0;
    m_pulse = 0;
  endtask
  // mode: 0 hunting for a seed, 1 confirming predictions, 2 locked
  task automatic model(input int d, input bit v, input bit c);
    int inc;
    m_pulse = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin
          m_mode = 1;
          m_exp = nx(d);
          m_run = 0;
        end
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_run++;
          m_exp = nx(d);
          if (m_run == LOCK) begin
            m_mode = 2;
            m_bad = 0;
          end
        end else if (d == 0) m_mode = 0;
        else begin
          m_exp = nx(d);
          m_run = 0;
        end
      end else begin
        if (d != m_exp) begin
          inc = BITCNT ? $countones(d ^ m_exp) : 1;
          m_pulse = 1;
          m_cnt = (m_cnt + inc > 65535) ? 65535 : m_cnt + inc;
          m_bad++;
          if (m_bad == UNLOCK) m_mode = 0;
        end else m_bad = 0;
        m_exp = nx(m_exp);
      end
    end
    if (c) m_cnt = 0;
  endtask
  task automatic step_a(input logic [7:0] d, input bit v, input bit c);
    @(negedge clk);
    a.data_in = d;
    a.valid = v;
    a.clear = c;
    @(posedge clk);
    #1;
    model(int'(d), v, c);
  endtask
  task automatic step_b(input logic [7:0] d, input bit v, input bit c);
    @(negedge clk);
    b.data_in = d;
    b.valid = v;
    b.clear = c;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    a.valid = 1'b0;
    a.clear = 1'b0;
    b.valid = 1'b0;
    b.clear = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask
  initial begin
    logic [7:0] lk_seq [5];
    int g, burst, d;
    bit v, c;
    lk_seq = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10};
    vt[0]  = '{8'h01, 1, 0, 0, 0, 0};
    vt[1]  = '{8'h80, 1, 0, 0, 0, 0};
    vt[2]  = '{8'h40, 1, 0, 0, 0, 0};
    vt[3]  = '{8'h20, 1, 0, 0, 0, 0};
    vt[4]  = '{8'h10, 1, 0, 1, 0, 0};
    vt[5]  = '{8'h89, 1, 0, 1, 1, 1};
    vt[6]  = '{8'h44, 1, 0, 1, 0, 1};
    vt[7]  = '{8'h00, 0, 0, 1, 0, 1};
    vt[8]  = '{8'hA2, 1, 0, 1, 0, 1};
    vt[9]  = '{8'hFF, 1, 0, 1, 1, E10};
    vt[10] = '{8'hFF, 1, 0, 1, 1, E11};
    vt[11] = '{8'hFF, 1, 0, 0, 1, E12};
    vt[12] = '{8'h00, 0, 1, 0, 0, 0};
    vt[13] = '{8'h05, 1, 0, 0, 0, 0};
    vt[14] = '{8'h02, 1, 0, 0, 0, 0};
    vt[15] = '{8'h01, 1, 0, 0, 0, 0};
    vt[16] = '{8'h80, 1, 0, 0, 0, 0};
    vt[17] = '{8'h40, 1, 0, 1, 0, 0};
    a.data_in = '0;
    a.valid = 1'b0;
    a.clear = 1'b0;
    b.data_in = '0;
    b.valid = 1'b0;
    b.clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset locked", a.locked, 0);
    chk("reset err_pulse", a.err_pulse, 0);
    chk("reset err_count", a.err_count, 0);
    chk("reset b err_count", b.err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_a(8'h00, 1, 0);
      chk($sformatf("zero%0d locked", i), a.locked, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step_a(lk_seq[i], 1, 0);
      chk($sformatf("after zeros lock%0d", i), a.locked, i == 4);
    end
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step_a(vt[i].d, vt[i].v, vt[i].c);
      chk($sformatf("vec%0d locked", i), a.locked, vt[i].lk);
      chk($sformatf("vec%0d err_pulse", i), a.err_pulse, vt[i].ep);
      chk($sformatf("vec%0d err_count", i), a.err_count, vt[i].ec);
    end
    step_a(8'hFF, 1, 0);
    chk("pre-reset err_pulse", a.err_pulse, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async locked", a.locked, 0);
    chk("async err_pulse", a.err_pulse, 0);
    chk("async err_count", a.err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step_a(lk_seq[i], 1, 0);
      chk($sformatf("relock%0d", i), a.locked, i == 4);
    end
    do_reset();
    for (int i = 0; i < 5; i++) step_b(lk_seq[i], 1, 0);
    chk("sat locked", b.locked, 1);
    for (int i = 0; i < 5; i++) begin
      step_b(8'hFF, 1, 0);
      chk($sformatf("sat err%0d count", i), b.err_count, BITCNT ? 3 : (i + 1 > 3 ? 3 : i + 1));
      chk($sformatf("sat err%0d locked", i), b.locked, 1);
    end
    step_b(8'hFF, 1, 1);
    chk("clear+err count", b.err_count, 0);
    chk("clear+err pulse", b.err_pulse, 1);
    chk("clear+err locked", b.locked, 1);
    step_b(8'hFF, 1, 0);
    chk("post-clear count", b.err_count, BITCNT ? 3 : 1);
    step_b(8'hFF, 1, 0);
    chk("eighth err unlock", b.locked, 0);
    step_b(8'h00, 0, 0);
    do_reset();
    g = 1;
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      v = $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 63) == 0;
      d = g;
      if (v) begin
        if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(1, 4);
        if (burst > 0) begin
          d = g ^ int'($urandom_range(1, 255));
          burst--;
        end else if ($urandom_range(0, 29) == 0) d = g ^ (1 << $urandom_range(0, 7));
        else if ($urandom_range(0, 99) == 0) d = 0;
        g = nx(g);
      end
      step_a(8'(d), v, c);
      chk("rand locked", a.locked, m_mode == 2);
      chk("rand err_pulse", a.err_pulse, m_pulse);
      chk("rand err_count", a.err_count, m_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Downstream consumer of the two-tap Fibonacci LFSR byte stream. Samples one byte per valid cycle and predicts the next byte using the same tap rule. It locks after a run of correct predictions, then counts errors while locked and drops lock after consecutive mismatches. Used as the self-check stage for LFSR generators in test and bring-up builds.

## Interface
- TAP_ONE, 2, first feedback tap index (0–7); must match the generator
- TAP_TWO, 4, second feedback tap index (0–7); must match the generator
- LOCK_COUNT, 4, consecutive correct predictions required to lock (≥1)
- UNLOCK_ERRORS, 3, consecutive locked mismatches that drop lock (≥1)
- ERR_CNT_W, 16, error counter width
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- data_in  input  8  LFSR byte under check
- valid  input  1  data_in is sampled this cycle
- clear  input  1  synchronous zero of err_count
- locked  output  1  checker is in LOCKED
- err_pulse  output  1  one-cycle pulse per locked mismatch
- err_count  output  ERR_CNT_W  saturating error count

## Operation
- Prediction function: next(x) = {x[0]^x[TAP_ONE]^x[TAP_TWO], x[7:1]}.
- Three states:
  - SEARCH (reset state): on valid with data_in != 0, set expected = next(data_in) and match_cnt = 0, then go to SYNC. data_in == 0 is the generator lock-up value; it is ignored and the state stays SEARCH.
  - SYNC: on valid:
    - Match (data_in == expected): match_cnt++, expected = next(data_in). When match_cnt reaches LOCK_COUNT, go to LOCKED and clear consec_err.
    - Mismatch: reseed with expected = next(data_in) and match_cnt = 0, staying in SYNC. If data_in == 0 on a mismatch, return to SEARCH instead.
  - LOCKED: on valid, expected = next(expected) (flywheel; data_in is not used to reseed).
    - Mismatch: err_pulse, err_count++, consec_err++. When consec_err reaches UNLOCK_ERRORS, go to SEARCH.
    - Match: consec_err = 0.
- valid low: all state, expected and counters hold. err_pulse is 0.
- err_count saturates at all-ones and never wraps. Errors are counted only in LOCKED.
- clear: err_count = 0 on the next edge, with priority over a same-cycle increment. err_pulse still fires. clear does not affect FSM state or lock.
- Reset mid-stream: all outputs return to reset values immediately (asynchronous). The FSM restarts in SEARCH.

## Timing
- Reset values: locked = 0, err_pulse = 0, err_count = 0, state = SEARCH, expected = 0, match_cnt = 0, consec_err = 0.
- All outputs are registered. Input sampled at edge N is reflected in locked, err_pulse and err_count after edge N (visible in cycle N+1).
- Lock latency: 1 + LOCK_COUNT valid samples from the first nonzero sample. Back-to-back valid samples lock in LOCK_COUNT+1 cycles.
- Unlock: locked deasserts in the cycle after the UNLOCK_ERRORS-th consecutive mismatch. err_pulse fires in that same cycle.
- No backpressure. Every valid sample is consumed.

## Configuration
- LFSR_CHK_BITCNT_EN defined: each locked mismatch adds popcount(data_in ^ expected) (1–8) to err_count, with saturation. This gives a bit-error count.
- LFSR_CHK_BITCNT_EN undefined: each locked mismatch adds 1. This gives a word-error count.
- FSM, lock and err_pulse behaviour are identical in both builds.

## Structure
- Package lfsr_chk_pkg holds:
  - the state enum (SEARCH, SYNC, LOCKED)
  - the LFSR_W = 8 constant
  - the next-state function next(x, t1, t2)
- Sub-module lfsr_chk_popcnt (8-bit population count, combinational) is instantiated only under LFSR_CHK_BITCNT_EN.

## Test plan
Default parameters; generator sequence from seed 0x01 is 0x01, 0x80, 0x40, 0x20, 0x10, 0x88, …
- Lock: reset, then feed 0x01, 0x80, 0x40, 0x20, 0x10 back-to-back → locked = 1 in the cycle after 0x10; err_count = 0.
- Zero lock-up: feed 0x00 ×10, then 0x01 → state stays SEARCH through the zeros; 0x01 moves to SYNC; locked stays 0.
- Locked error: after lock, feed 0x89 in place of 0x88 → one err_pulse; err_count = 1 (word build) or 1 (bit build, single bit differs); locked stays 1. The following correct sample is predicted from expected, not from 0x89.
- Unlock: after lock, feed 3 consecutive wrong bytes → err_pulse ×3, err_count = 3, locked = 0 after the third; the next nonzero valid sample re-enters SYNC.
- Saturation and clear: ERR_CNT_W = 2, force 5 locked errors with UNLOCK_ERRORS = 8 → err_count sticks at 3. Assert clear together with an error → err_count = 0 and err_pulse = 1.
- Async reset mid-lock: drop reset_n between clock edges → locked, err_count and err_pulse read 0 immediately; a full relock is required afterwards.
